// File: rtl/dds_sweep_ctrl_if.sv
// Configuration and generator-drive bundle for the DDS frequency-sweep sequencer.
// Latency: wires only. Backpressure: cfg_valid/cfg_ready; F_word/P_word/sin_en are unthrottled.
// Ports: cfg_* (sweep config, valid/ready), F_word/P_word/sin_en (to DDS generator).
interface dds_sweep_ctrl_if #(
   parameter int FW_W    = 8,
   parameter int DWELL_W = 16
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic [FW_W-1:0]    cfg_start_f;
   logic [FW_W-1:0]    cfg_stop_f;
   logic [FW_W-1:0]    cfg_step;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [1:0]         cfg_mode;
   logic [FW_W-1:0]    cfg_phase;
   logic [FW_W-1:0]    F_word;
   logic [FW_W-1:0]    P_word;
   logic               sin_en;

   // master: register/control side that offers configs and watches the generator drive
   modport master (
      output cfg_valid, cfg_start_f, cfg_stop_f, cfg_step, cfg_dwell, cfg_mode, cfg_phase,
      input  cfg_ready, F_word, P_word, sin_en
   );

   // slave: the sweep sequencer itself
   modport slave (
      input  cfg_valid, cfg_start_f, cfg_stop_f, cfg_step, cfg_dwell, cfg_mode, cfg_phase,
      output cfg_ready, F_word, P_word, sin_en
   );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps F_word start->stop, holding each word max(dwell,1) cycles.
// Latency: registered outputs, F_word/sin_en valid the edge after start; abort clears them the next edge.
// Backpressure: cfg_ready high only while idle; cfg_valid stalls during a sweep.
// Ports: clk, rst (async, active-high), bus (cfg handshake + generator drive), start, abort, busy, done.
module dds_sweep_ctrl #(
   parameter int FW_W    = 8,
   parameter int DWELL_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   dds_sweep_ctrl_if.slave  bus,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state_q, state_nxt;

   // captured configuration
   logic [FW_W-1:0]    start_q, stop_q, step_q, phase_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [1:0]         mode_q;

   // live sweep state; triangle mode swaps the endpoints here, not in the config
   logic [FW_W-1:0]    run_start_q, run_start_nxt;
   logic [FW_W-1:0]    run_stop_q, run_stop_nxt;
   logic               up_q, up_nxt;
   logic [DWELL_W-1:0] cnt_q, cnt_nxt;

   logic [FW_W-1:0]    f_q, f_nxt, p_q, p_nxt;
   logic               en_q, en_nxt, done_q, done_nxt, busy_q, busy_nxt, ready_q, ready_nxt;

   logic               hs;
   logic [FW_W-1:0]    step_eff, use_start, use_stop, use_phase;
   logic [DWELL_W-1:0] dwell_eff;

   // One step toward stop, clamped at stop; the extra bit catches wrap in both directions.
   function automatic logic [FW_W-1:0] next_word(input logic [FW_W-1:0] f,
                                                 input logic [FW_W-1:0] step,
                                                 input logic [FW_W-1:0] stop,
                                                 input logic            up);
      logic [FW_W:0]   t;
      logic [FW_W-1:0] r;
      if (up) begin
         t = {1'b0, f} + {1'b0, step};
         r = (t > {1'b0, stop}) ? stop : t[FW_W-1:0];
      end else begin
         t = {1'b0, f} - {1'b0, step};
         r = (t[FW_W] || (t < {1'b0, stop})) ? stop : t[FW_W-1:0];
      end
      return r;
   endfunction

   assign hs        = bus.cfg_valid && ready_q;
   assign step_eff  = (step_q == '0)  ? FW_W'(1)    : step_q;
   assign dwell_eff = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
   // a config offered alongside start takes effect for that start
   assign use_start = hs ? bus.cfg_start_f : start_q;
   assign use_stop  = hs ? bus.cfg_stop_f  : stop_q;
   assign use_phase = hs ? bus.cfg_phase   : phase_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         phase_q <= '0;
         dwell_q <= '0;
         mode_q  <= '0;
      end else if (hs) begin
         start_q <= bus.cfg_start_f;
         stop_q  <= bus.cfg_stop_f;
         step_q  <= bus.cfg_step;
         phase_q <= bus.cfg_phase;
         dwell_q <= bus.cfg_dwell;
         mode_q  <= bus.cfg_mode;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         run_start_q <= '0;
         run_stop_q  <= '0;
         up_q        <= 1'b0;
         cnt_q       <= '0;
         f_q         <= '0;
         p_q         <= '0;
         en_q        <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_nxt;
         run_start_q <= run_start_nxt;
         run_stop_q  <= run_stop_nxt;
         up_q        <= up_nxt;
         cnt_q       <= cnt_nxt;
         f_q         <= f_nxt;
         p_q         <= p_nxt;
         en_q        <= en_nxt;
         done_q      <= done_nxt;
         busy_q      <= busy_nxt;
         ready_q     <= ready_nxt;
      end
   end

   always_comb begin
      state_nxt     = state_q;
      run_start_nxt = run_start_q;
      run_stop_nxt  = run_stop_q;
      up_nxt        = up_q;
      cnt_nxt       = cnt_q;
      f_nxt         = f_q;
      p_nxt         = p_q;
      en_nxt        = en_q;
      done_nxt      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_nxt     = RUN;
               f_nxt         = use_start;
               p_nxt         = use_phase;
               en_nxt        = 1'b1;
               cnt_nxt       = DWELL_W'(1);
               run_start_nxt = use_start;
               run_stop_nxt  = use_stop;
               up_nxt        = (use_stop >= use_start);
            end
         end
         RUN: begin
            if (cnt_q == dwell_eff) begin
               // next word loads on the same edge, so words are back to back
               cnt_nxt = DWELL_W'(1);
               if (f_q == run_stop_q) begin
                  case (mode_q)
                     2'd1: f_nxt = run_start_q;
                     2'd2: begin
                        // bounce off the endpoint without repeating it
                        up_nxt        = ~up_q;
                        run_start_nxt = run_stop_q;
                        run_stop_nxt  = run_start_q;
                        f_nxt         = next_word(f_q, step_eff, run_start_q, ~up_q);
                     end
                     default: begin
                        state_nxt = DONE;
                        f_nxt     = '0;
                        en_nxt    = 1'b0;
                        done_nxt  = 1'b1;
                     end
                  endcase
               end else begin
                  f_nxt = next_word(f_q, step_eff, run_stop_q, up_q);
               end
            end else begin
               cnt_nxt = cnt_q + DWELL_W'(1);
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      if (abort) begin
         state_nxt = IDLE;
         f_nxt     = '0;
         p_nxt     = '0;
         en_nxt    = 1'b0;
         done_nxt  = 1'b0;
      end

      busy_nxt  = (state_nxt != IDLE);
      // ready only once a full cycle has been spent in IDLE
      ready_nxt = (state_q == IDLE) && (state_nxt == IDLE);
   end

   assign bus.cfg_ready = ready_q;
   assign bus.F_word    = f_q;
   assign bus.P_word    = p_q;
   assign bus.sin_en    = en_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed sweeps with a queue of expected (F_word, P_word) per enabled cycle.
// A negedge monitor pops one entry per sin_en cycle and checks done pulses independently of stimulus.
module tb_dds_sweep_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic busy, done;

   dds_sweep_ctrl_if #(.FW_W(8), .DWELL_W(16)) bus();

   dds_sweep_ctrl #(.FW_W(8), .DWELL_W(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .start (start),
      .abort (abort),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] f;
      logic [7:0] p;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   done_cyc = -100;
   logic prev_en = 1'b0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(posedge clk) cyc = cyc + 1;

   // scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (bus.sin_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", int'(bus.F_word), -1);
         end else begin
            e = exp_q.pop_front();
            check("F_word", int'(bus.F_word), int'(e.f));
            check("P_word", int'(bus.P_word), int'(e.p));
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         check("done_after_last_word", int'(prev_en), 1);
         check("done_sin_en", int'(bus.sin_en), 0);
         check("done_F_word", int'(bus.F_word), 0);
      end
      prev_en = bus.sin_en;
   end

   task automatic push(input logic [7:0] f, input logic [7:0] p, input int n);
      exp_t e;
      e.f = f;
      e.p = p;
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endtask

   task automatic set_fields(input logic [7:0] sf, input logic [7:0] ef, input logic [7:0] st,
                             input logic [7:0] ph, input logic [15:0] dw, input logic [1:0] md);
      bus.cfg_start_f = sf;
      bus.cfg_stop_f  = ef;
      bus.cfg_step    = st;
      bus.cfg_phase   = ph;
      bus.cfg_dwell   = dw;
      bus.cfg_mode    = md;
   endtask

   task automatic do_cfg(input logic [7:0] sf, input logic [7:0] ef, input logic [7:0] st,
                         input logic [7:0] ph, input logic [15:0] dw, input logic [1:0] md,
                         output int acc_cyc, output int acc_busy);
      bit ok;
      ok = 1'b0;
      acc_cyc = -1;
      acc_busy = -1;
      @(posedge clk); #1;
      set_fields(sf, ef, st, ph, dw, md);
      bus.cfg_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (bus.cfg_ready) begin
            ok = 1'b1;
            acc_cyc = cyc;
            acc_busy = int'(busy);
         end
      end
      check("cfg_accepted", int'(ok), 1);
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      // garbage outside the handshake must be ignored
      set_fields(8'hEE, 8'hEE, 8'hEE, 8'hEE, 16'hEEEE, 2'd2);
   endtask

   task automatic do_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (!busy) ok = 1'b1;
      end
      check("idle_reached", int'(ok), 1);
   endtask

   task automatic end_mode0(input string name, input int d0);
      check({name, "_done_count"}, done_cnt, d0 + 1);
      check({name, "_sin_en_off"}, int'(bus.sin_en), 0);
      check({name, "_F_zero"}, int'(bus.F_word), 0);
      check({name, "_words_left"}, exp_q.size(), 0);
   endtask

   task automatic abort_checks(input string name, input int d0);
      check({name, "_sin_en"}, int'(bus.sin_en), 0);
      check({name, "_F_word"}, int'(bus.F_word), 0);
      check({name, "_P_word"}, int'(bus.P_word), 0);
      check({name, "_busy"}, int'(busy), 0);
      check({name, "_no_done"}, done_cnt, d0);
      check({name, "_words_left"}, exp_q.size(), 0);
   endtask

   initial begin
      int acc, accb, d0;
      bus.cfg_valid = 1'b0;
      set_fields(8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 2'd0);

      // reset state
      @(negedge clk);
      check("rst_F_word", int'(bus.F_word), 0);
      check("rst_P_word", int'(bus.P_word), 0);
      check("rst_sin_en", int'(bus.sin_en), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_cfg_ready", int'(bus.cfg_ready), 1);
      @(posedge clk); #1;
      rst = 1'b0;

      // basic up sweep 10->40 step 10 dwell 3
      do_cfg(8'd10, 8'd40, 8'd10, 8'h33, 16'd3, 2'd0, acc, accb);
      push(8'd10, 8'h33, 3); push(8'd20, 8'h33, 3); push(8'd30, 8'h33, 3); push(8'd40, 8'h33, 3);
      d0 = done_cnt;
      do_start();
      wait_idle();
      end_mode0("up", d0);

      // overshoot clamp 10->35
      do_cfg(8'd10, 8'd35, 8'd10, 8'h01, 16'd2, 2'd0, acc, accb);
      push(8'd10, 8'h01, 2); push(8'd20, 8'h01, 2); push(8'd30, 8'h01, 2); push(8'd35, 8'h01, 2);
      d0 = done_cnt;
      do_start();
      wait_idle();
      end_mode0("clamp", d0);

      // down sweep 200->180 step 15
      do_cfg(8'd200, 8'd180, 8'd15, 8'h02, 16'd2, 2'd0, acc, accb);
      push(8'd200, 8'h02, 2); push(8'd185, 8'h02, 2); push(8'd180, 8'h02, 2);
      d0 = done_cnt;
      do_start();
      wait_idle();
      end_mode0("down", d0);

      // no wrap: 250->255 step 10
      do_cfg(8'd250, 8'd255, 8'd10, 8'h03, 16'd1, 2'd0, acc, accb);
      push(8'd250, 8'h03, 1); push(8'd255, 8'h03, 1);
      d0 = done_cnt;
      do_start();
      wait_idle();
      end_mode0("nowrap", d0);

      // triangle 0<->20 step 10 dwell 1, aborted after 8 words
      do_cfg(8'd0, 8'd20, 8'd10, 8'h11, 16'd1, 2'd2, acc, accb);
      push(8'd0, 8'h11, 1); push(8'd10, 8'h11, 1); push(8'd20, 8'h11, 1); push(8'd10, 8'h11, 1);
      push(8'd0, 8'h11, 1); push(8'd10, 8'h11, 1); push(8'd20, 8'h11, 1); push(8'd10, 8'h11, 1);
      d0 = done_cnt;
      do_start();
      repeat (7) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      abort_checks("tri_abort", d0);

      // repeat mode 5..7 with step 0 and dwell 0 acting as 1
      do_cfg(8'd5, 8'd7, 8'd0, 8'h22, 16'd0, 2'd1, acc, accb);
      push(8'd5, 8'h22, 1); push(8'd6, 8'h22, 1); push(8'd7, 8'h22, 1);
      push(8'd5, 8'h22, 1); push(8'd6, 8'h22, 1); push(8'd7, 8'h22, 1); push(8'd5, 8'h22, 1);
      d0 = done_cnt;
      do_start();
      repeat (6) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      abort_checks("rep_abort", d0);

      // config offered while busy stalls until a cycle after return to IDLE
      do_cfg(8'd1, 8'd3, 8'd1, 8'h44, 16'd4, 2'd0, acc, accb);
      push(8'd1, 8'h44, 4); push(8'd2, 8'h44, 4); push(8'd3, 8'h44, 4);
      d0 = done_cnt;
      do_start();
      fork
         wait_idle();
         do_cfg(8'd50, 8'd52, 8'd1, 8'h55, 16'd1, 2'd0, acc, accb);
      join
      check("busy_cfg_done_count", done_cnt, d0 + 1);
      check("busy_cfg_accept_cycle", acc, done_cyc + 2);
      check("busy_cfg_accept_idle", accb, 0);

      // cfg_valid together with start uses the new config
      @(negedge clk);
      check("hs_ready_idle", int'(bus.cfg_ready), 1);
      push(8'd100, 8'h77, 1); push(8'd95, 8'h77, 1); push(8'd90, 8'h77, 1);
      d0 = done_cnt;
      @(posedge clk); #1;
      set_fields(8'd100, 8'd90, 8'd5, 8'h77, 16'd1, 2'd0);
      bus.cfg_valid = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      start = 1'b0;
      set_fields(8'hEE, 8'hEE, 8'hEE, 8'hEE, 16'hEEEE, 2'd2);
      wait_idle();
      end_mode0("cfg_with_start", d0);

      // asynchronous reset mid-sweep, reusing the retained 100->90 config
      push(8'd100, 8'h77, 1);
      do_start();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_F_word", int'(bus.F_word), 0);
      check("midrst_P_word", int'(bus.P_word), 0);
      check("midrst_sin_en", int'(bus.sin_en), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_cfg_ready", int'(bus.cfg_ready), 1);
      check("midrst_words_left", exp_q.size(), 0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;

      // reset cleared the config: 0->0, one word, then done
      push(8'd0, 8'h00, 1);
      d0 = done_cnt;
      do_start();
      wait_idle();
      end_mode0("zero_cfg", d0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
      $fatal(1);
   end
endmodule
